dsp_data_router: RTL and testbench
==================================

// Module: dsp_data_router
// PURPOSE
//  1:3 AXI-Stream packet router, the fan-out counterpart of the 3:1 DSP data switch.
//  One input stream goes to one of three output streams. The route comes from an
//  8-bit select stream and changes only on packet boundaries (tlast).
//  Route values > 2 put the block in discard mode: input is consumed and dropped.
// PARAMETERS
//  DATA_WIDTH_IN_BYTES  4   data width of every tdata bus, in bytes (W = 8*DATA_WIDTH_IN_BYTES)
//  DROP_CNT_WIDTH       16  width of the saturating dropped-beat counter
// PORTS
//  ACLK               in   1   single clock, all logic on rising edge
//  ARESETn            in   1   asynchronous active-low reset
//  s_axis_tdata_sel   in   8   requested route: 0,1,2 = output N; >2 = discard
//  s_axis_tvalid_sel  in   1   select valid
//  s_axis_tready_sel  out  1   select ready (pending slot empty)
//  s_axis_tdata       in   W   input data
//  s_axis_tvalid      in   1   input valid
//  s_axis_tlast       in   1   input end of packet
//  s_axis_tready      out  1   input ready
//  m_axis_tdata_N     out  W   output N data, N = 0..2
//  m_axis_tvalid_N    out  1   output N valid
//  m_axis_tlast_N     out  1   output N end of packet
//  m_axis_tready_N    in   1   output N ready
//  RDY                out  1   1 = active route is 0..2; 0 = discard mode
//  drop_cnt           out  DROP_CNT_WIDTH  dropped beats, saturating, no wrap
// BEHAVIOUR
//  Reset values: route=0, pending empty, state=IDLE, s_axis_tready_sel=1,
//  all m_axis_tvalid_N=0, tlast_N=0, tdata_N=0, s_axis_tready=0 (goes to 1 on the
//  first clock after release), RDY=1, drop_cnt=0.
//  Select channel: one-entry pending register. A select handshake loads pending and
//  drops s_axis_tready_sel. s_axis_tready_sel returns to 1 in the cycle after the
//  pending value is applied. While pending is full, further selects are back-pressured.
//  Packet FSM:
//   - IDLE: at a packet boundary; no beat of the current packet has been accepted.
//     If pending is full, route<=pending and pending is cleared in that cycle. While
//     pending is full in IDLE, s_axis_tready=0, so no beat is accepted before the
//     route is applied.
//   - IDLE->FWD: a beat is accepted with tlast=0.
//   - IDLE->IDLE: a beat is accepted with tlast=1 (single-beat packet).
//   - FWD->IDLE: a beat is accepted with tlast=1. A select accepted in the same
//     cycle applies to the next packet, never to the current one.
//  Forwarding: the output register slice carries data/last/valid with 1-cycle
//  latency from the input handshake. Only m_axis_tvalid_<route> can be 1. The other
//  outputs hold tvalid=0, and their tdata/tlast are don't-care.
//  Skid buffer: a 2-entry skid buffer gives full throughput (1 beat/clk) with a
//  registered s_axis_tready. s_axis_tready = skid not full.
//  Output hold: an output's tdata/tlast stay stable while tvalid=1 and tready=0.
//  Route change: a new route is applied only when the output slice is empty (the
//  previous tail beat has been accepted downstream). No beat of packet k+1 may
//  appear on an output before the tlast of packet k has been accepted.
//  Discard (route>2): RDY=0 from the cycle after the route is applied; s_axis_tready=1;
//  every accepted beat is dropped and drop_cnt increments, holding at all-ones;
//  tlast still drives the FSM. Selecting a route 0..2 restores RDY=1 from the next
//  packet.
//  Reset mid-packet: asynchronous clear of all state; the partial packet is lost.
//  Output tvalid falls immediately on ARESETn low.
// STRUCTURE
//  Shared header dsp_data_switch_defs.vh, also used by the 3:1 switch, holds:
//   - ROUTE_0/1/2 constants, ROUTE_MAX=2, SEL_WIDTH=8
//   - FSM state encodings ST_IDLE, ST_FWD
//  Sub-module axis_skid_buffer (parameter W+1 for data+last) is the input slice,
//  instantiated once.
// TESTING
//  1 Reset route 0; 3-beat packet A1..A3 with tready_0=1 -> beats appear on out0 at
//    t+1..t+3, tlast on A3; out1/out2 tvalid stay 0.
//  2 Select 2 sent mid-packet on route 0 -> current packet completes on out0, the next
//    packet goes fully to out2; s_axis_tready_sel=0 until that switch.
//  3 Select 7, then a 4-beat packet -> RDY=0, s_axis_tready=1, no output valid,
//    drop_cnt=4; select 1 then restores RDY=1 and delivers on out1.
//  4 Back-pressure: m_axis_tready_1 toggles 1,0,0,1 during a 5-beat stream -> no beat
//    lost or duplicated, tdata stable while stalled, s_axis_tready deasserts within
//    2 clocks.
//  5 Select arrives in the same cycle as a tlast beat; a second select arrives while
//    pending is full -> the first applies to the next packet, the second is held off
//    (tready_sel=0).
//  6 ARESETn pulsed low mid-packet -> all tvalid 0 asynchronously, route=0, RDY=1,
//    drop_cnt=0; the next packet is routed cleanly to out0.

Source files
------------

// File: rtl/dsp_data_router_pkg.sv
// Route constants and packet FSM encoding shared by the DSP router and its 3:1 switch sibling.
// Routes above ROUTE_MAX select discard mode.
package dsp_data_router_pkg;
   localparam int SEL_WIDTH = 8;
   localparam logic [SEL_WIDTH-1:0] ROUTE_0   = 8'd0;
   localparam logic [SEL_WIDTH-1:0] ROUTE_1   = 8'd1;
   localparam logic [SEL_WIDTH-1:0] ROUTE_2   = 8'd2;
   localparam logic [SEL_WIDTH-1:0] ROUTE_MAX = ROUTE_2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FWD  = 1'b1
   } pkt_state_e;

   // One-hot output valid mask for a route; discard routes map to no output.
   function automatic logic [2:0] route_onehot(input logic [SEL_WIDTH-1:0] r);
      return (r > ROUTE_MAX) ? 3'b000 : (3'b001 << r[1:0]);
   endfunction
endpackage

// File: rtl/dsp_data_router_skid.sv
// Two-entry input skid buffer with registered ready; an empty buffer passes the
// incoming beat straight through so the router sees it in the same cycle.
module dsp_data_router_skid #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] s_dat,
   input  logic         s_vld,
   output logic         s_rdy,
   output logic [W-1:0] m_dat,
   output logic         m_vld,
   input  logic         m_rdy
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, rd_ptr_q, rdy_q;
   logic [1:0]   cnt_q, cnt_d;
   logic         empty, in_hs, wr_en, rd_en;

   assign empty = (cnt_q == 2'd0);
   assign in_hs = s_vld & rdy_q;
   assign s_rdy = rdy_q;
   assign m_vld = !empty | in_hs;
   assign m_dat = empty ? s_dat : mem_q[rd_ptr_q];
   assign wr_en = in_hs & !(empty & m_rdy);
   assign rd_en = !empty & m_rdy;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en && !rd_en)
         cnt_d = cnt_q + 2'd1;
      else if (!wr_en && rd_en)
         cnt_d = cnt_q - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         rdy_q    <= 1'b0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rdy_q <= (cnt_d != 2'd2);
         if (wr_en) wr_ptr_q <= ~wr_ptr_q;
         if (rd_en) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= s_dat;
   end
endmodule

// File: rtl/dsp_data_router.sv
// 1:3 AXI-Stream packet router: routes whole packets to one of three outputs (or drops
// them) using a select stream that only takes effect at packet boundaries.
module dsp_data_router
   import dsp_data_router_pkg::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 4,
   parameter int DROP_CNT_WIDTH      = 16
) (
   input  logic                            ACLK,
   input  logic                            ARESETn,
   input  logic [SEL_WIDTH-1:0]            s_axis_tdata_sel,
   input  logic                            s_axis_tvalid_sel,
   output logic                            s_axis_tready_sel,
   input  logic [8*DATA_WIDTH_IN_BYTES-1:0] s_axis_tdata,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready,
   output logic [8*DATA_WIDTH_IN_BYTES-1:0] m_axis_tdata_0,
   output logic                            m_axis_tvalid_0,
   output logic                            m_axis_tlast_0,
   input  logic                            m_axis_tready_0,
   output logic [8*DATA_WIDTH_IN_BYTES-1:0] m_axis_tdata_1,
   output logic                            m_axis_tvalid_1,
   output logic                            m_axis_tlast_1,
   input  logic                            m_axis_tready_1,
   output logic [8*DATA_WIDTH_IN_BYTES-1:0] m_axis_tdata_2,
   output logic                            m_axis_tvalid_2,
   output logic                            m_axis_tlast_2,
   input  logic                            m_axis_tready_2,
   output logic                            RDY,
   output logic [DROP_CNT_WIDTH-1:0]       drop_cnt
);
   localparam int W = 8 * DATA_WIDTH_IN_BYTES;

   pkt_state_e                state_q;
   logic [SEL_WIDTH-1:0]      route_q, route_d, pend_q, pend_d;
   logic                      pend_full_q, pend_full_d, rdy_q, rdy_d;
   logic [2:0]                ovld_q, ovld_d, m_rdy;
   logic [W-1:0]              odat_q, odat_d, sk_dat;
   logic                      olast_q, olast_d, sk_last, sk_vld, skid_rdy;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   logic                      discard, slice_free, hold, apply, pop_ok, pop, sel_hs;

   assign m_rdy      = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
   assign discard    = (route_q > ROUTE_MAX);
   assign slice_free = ((ovld_q & ~m_rdy) == 3'b000);
   // A pending route blocks the next packet until it has been applied.
   assign hold       = (state_q == ST_IDLE) && pend_full_q;
   assign apply      = hold && (ovld_q == 3'b000);
   assign pop_ok     = !hold && (discard || slice_free);
   assign pop        = sk_vld && pop_ok;
   assign sel_hs     = s_axis_tvalid_sel && !pend_full_q;

   dsp_data_router_skid #(.W(W + 1)) u_skid (
      .clk   (ACLK),
      .rst_n (ARESETn),
      .s_dat ({s_axis_tlast, s_axis_tdata}),
      .s_vld (s_axis_tvalid && !hold),
      .s_rdy (skid_rdy),
      .m_dat ({sk_last, sk_dat}),
      .m_vld (sk_vld),
      .m_rdy (pop_ok)
   );

   always_comb begin
      route_d     = route_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      rdy_d       = rdy_q;
      ovld_d      = ovld_q & ~m_rdy;
      odat_d      = odat_q;
      olast_d     = olast_q;
      drop_d      = drop_q;
      if (apply) begin
         route_d     = pend_q;
         rdy_d       = (pend_q <= ROUTE_MAX);
         pend_full_d = 1'b0;
      end
      if (sel_hs) begin
         pend_d      = s_axis_tdata_sel;
         pend_full_d = 1'b1;
      end
      if (pop && !discard) begin
         ovld_d  = route_onehot(route_q);
         odat_d  = sk_dat;
         olast_d = sk_last;
      end
      if (pop && discard && (drop_q != '1))
         drop_d = drop_q + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= ST_IDLE;
         route_q     <= ROUTE_0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         rdy_q       <= 1'b1;
         ovld_q      <= 3'b000;
         odat_q      <= '0;
         olast_q     <= 1'b0;
         drop_q      <= '0;
      end else begin
         if (pop)
            state_q <= sk_last ? ST_IDLE : ST_FWD;
         route_q     <= route_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         rdy_q       <= rdy_d;
         ovld_q      <= ovld_d;
         odat_q      <= odat_d;
         olast_q     <= olast_d;
         drop_q      <= drop_d;
      end
   end

   assign s_axis_tready     = skid_rdy && !hold;
   assign s_axis_tready_sel = !pend_full_q;
   assign m_axis_tdata_0    = odat_q;
   assign m_axis_tdata_1    = odat_q;
   assign m_axis_tdata_2    = odat_q;
   assign m_axis_tlast_0    = olast_q;
   assign m_axis_tlast_1    = olast_q;
   assign m_axis_tlast_2    = olast_q;
   assign m_axis_tvalid_0   = ovld_q[0];
   assign m_axis_tvalid_1   = ovld_q[1];
   assign m_axis_tvalid_2   = ovld_q[2];
   assign RDY               = rdy_q;
   assign drop_cnt          = drop_q;
endmodule

// File: tb/tb_dsp_data_router.sv
// Directed bench for dsp_data_router: hand-computed packets, routes and counter values.
// A negedge monitor collects delivered beats per output and checks output hold under stall.
module tb_dsp_data_router;
   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [7:0]  s_axis_tdata_sel = '0;
   logic        s_axis_tvalid_sel = 1'b0;
   logic        s_axis_tready_sel;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata_0, m_axis_tdata_1, m_axis_tdata_2;
   logic        m_axis_tvalid_0, m_axis_tvalid_1, m_axis_tvalid_2;
   logic        m_axis_tlast_0, m_axis_tlast_1, m_axis_tlast_2;
   logic        m_axis_tready_0 = 1'b1, m_axis_tready_1 = 1'b1, m_axis_tready_2 = 1'b1;
   logic        RDY;
   logic [15:0] drop_cnt;

   int errors = 0;
   int checks = 0;
   logic [32:0] oq0[$], oq1[$], oq2[$];
   logic [2:0]  mv, mr;
   logic [32:0] md [3];
   logic [32:0] prev_dat [3];
   logic        prev_stall [3];

   always #5 ACLK = ~ACLK;

   dsp_data_router dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_axis_tdata_sel(s_axis_tdata_sel), .s_axis_tvalid_sel(s_axis_tvalid_sel),
      .s_axis_tready_sel(s_axis_tready_sel),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata_0(m_axis_tdata_0), .m_axis_tvalid_0(m_axis_tvalid_0),
      .m_axis_tlast_0(m_axis_tlast_0), .m_axis_tready_0(m_axis_tready_0),
      .m_axis_tdata_1(m_axis_tdata_1), .m_axis_tvalid_1(m_axis_tvalid_1),
      .m_axis_tlast_1(m_axis_tlast_1), .m_axis_tready_1(m_axis_tready_1),
      .m_axis_tdata_2(m_axis_tdata_2), .m_axis_tvalid_2(m_axis_tvalid_2),
      .m_axis_tlast_2(m_axis_tlast_2), .m_axis_tready_2(m_axis_tready_2),
      .RDY(RDY), .drop_cnt(drop_cnt)
   );

   assign mv    = {m_axis_tvalid_2, m_axis_tvalid_1, m_axis_tvalid_0};
   assign mr    = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
   assign md[0] = {m_axis_tlast_0, m_axis_tdata_0};
   assign md[1] = {m_axis_tlast_1, m_axis_tdata_1};
   assign md[2] = {m_axis_tlast_2, m_axis_tdata_2};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge ACLK) begin
      if (!ARESETn) begin
         for (int n = 0; n < 3; n++) prev_stall[n] = 1'b0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            if (prev_stall[n])
               chk($sformatf("hold_out%0d", n), {mv[n], md[n]}, {1'b1, prev_dat[n]});
            prev_stall[n] = mv[n] & ~mr[n];
            prev_dat[n]   = md[n];
            if (mv[n] && mr[n]) begin
               case (n)
                  0:       oq0.push_back(md[n]);
                  1:       oq1.push_back(md[n]);
                  default: oq2.push_back(md[n]);
               endcase
            end
         end
      end
   end

   // Entered and left at posedge+1; holds the beat until accepted.
   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
      @(negedge ACLK);
      while (!s_axis_tready && n < 100) begin @(negedge ACLK); n++; end
      if (n >= 100) chk("send_timeout", s_axis_tready, 1);
      @(posedge ACLK); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic send_sel(input logic [7:0] v);
      int n = 0;
      s_axis_tdata_sel = v; s_axis_tvalid_sel = 1'b1;
      @(negedge ACLK);
      while (!s_axis_tready_sel && n < 100) begin @(negedge ACLK); n++; end
      if (n >= 100) chk("sel_timeout", s_axis_tready_sel, 1);
      @(posedge ACLK); #1;
      s_axis_tvalid_sel = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic send_pkt(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) send(base + 32'(i), (i == n - 1));
   endtask

   // Expects exactly n beats base..base+n-1 on the port, tlast on the final one.
   task automatic expect_port(input string tag, input int port, input logic [31:0] base,
                              input int n);
      logic [32:0] g[$];
      case (port)
         0:       begin g = oq0; oq0.delete(); end
         1:       begin g = oq1; oq1.delete(); end
         default: begin g = oq2; oq2.delete(); end
      endcase
      chk($sformatf("%s_len", tag), g.size(), n);
      for (int i = 0; i < n && i < g.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), g[i], {(i == n - 1), base + 32'(i)});
   endtask

   task automatic expect_empty(input string tag);
      chk($sformatf("%s_n0", tag), oq0.size(), 0);
      chk($sformatf("%s_n1", tag), oq1.size(), 0);
      chk($sformatf("%s_n2", tag), oq2.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #23;
      chk("rst_vld", mv, 3'b000);
      chk("rst_srdy", s_axis_tready, 0);
      chk("rst_sel_rdy", s_axis_tready_sel, 1);
      chk("rst_RDY", RDY, 1);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_out0", md[0], 33'h0);
      @(negedge ACLK); ARESETn = 1'b1;
      #1 chk("rel_srdy_low", s_axis_tready, 0);
      @(posedge ACLK); #1;
      chk("rel_srdy_high", s_axis_tready, 1);

      // 1: route 0, 3-beat packet, one-cycle latency
      for (int i = 0; i < 3; i++) begin
         send(32'hA000_0001 + 32'(i), (i == 2));
         chk($sformatf("t1_lat%0d", i), {mv, md[0]}, {3'b001, (i == 2), 32'hA000_0001 + 32'(i)});
      end
      idle(3);
      expect_port("t1_out0", 0, 32'hA000_0001, 3);
      expect_empty("t1");

      // 2: select 2 mid-packet on route 0
      send(32'hB000_0001, 1'b0);
      send_sel(8'd2);
      chk("t2_sel_busy", s_axis_tready_sel, 0);
      send(32'hB000_0002, 1'b0);
      send(32'hB000_0003, 1'b1);
      chk("t2_sel_still_busy", s_axis_tready_sel, 0);
      send_pkt(32'hC000_0001, 2);
      idle(4);
      expect_port("t2_out0", 0, 32'hB000_0001, 3);
      expect_port("t2_out2", 2, 32'hC000_0001, 2);
      expect_empty("t2");
      chk("t2_sel_rdy", s_axis_tready_sel, 1);
      chk("t2_RDY", RDY, 1);

      // 3: discard mode, then restore to route 1
      send_sel(8'd7);
      idle(2);
      chk("t3_RDY0", RDY, 0);
      chk("t3_srdy", s_axis_tready, 1);
      send_pkt(32'hD000_0001, 4);
      chk("t3_novld", mv, 3'b000);
      chk("t3_drop", drop_cnt, 4);
      idle(2);
      expect_empty("t3");
      send_sel(8'd1);
      idle(2);
      chk("t3_RDY1", RDY, 1);
      send_pkt(32'hE000_0001, 2);
      idle(3);
      expect_port("t3_out1", 1, 32'hE000_0001, 2);
      chk("t3_drop_hold", drop_cnt, 4);

      // 4: back-pressure on out1 during a 5-beat stream
      fork
         send_pkt(32'hF000_0001, 5);
         begin
            m_axis_tready_1 = 1'b1;
            @(posedge ACLK); #1 m_axis_tready_1 = 1'b0;
            @(posedge ACLK); #1;
            @(posedge ACLK); #1;
            chk("t4_srdy_low", s_axis_tready, 0);
            chk("t4_stall_dat", md[1], {1'b0, 32'hF000_0001});
            m_axis_tready_1 = 1'b1;
         end
      join
      idle(4);
      expect_port("t4_out1", 1, 32'hF000_0001, 5);
      expect_empty("t4");

      // 5: select with tlast beat, second select while pending full
      send(32'h5100_0000, 1'b0);
      s_axis_tdata = 32'h5100_0001; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
      s_axis_tdata_sel = 8'd0; s_axis_tvalid_sel = 1'b1;
      @(negedge ACLK);
      chk("t5_srdy", s_axis_tready, 1);
      chk("t5_sel_rdy", s_axis_tready_sel, 1);
      @(posedge ACLK); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      s_axis_tdata_sel = 8'd2;
      chk("t5_sel_held", s_axis_tready_sel, 0);
      fork
         send(32'h5200_0000, 1'b1);
         send_sel(8'd2);
      join
      chk("t5_pend2", s_axis_tready_sel, 0);
      send(32'h5300_0000, 1'b1);
      idle(4);
      expect_port("t5_out1", 1, 32'h5100_0000, 2);
      expect_port("t5_out0", 0, 32'h5200_0000, 1);
      expect_port("t5_out2", 2, 32'h5300_0000, 1);

      // 6: asynchronous reset mid-packet (route 2, out2 stalled)
      m_axis_tready_2 = 1'b0;
      send(32'h6100_0000, 1'b0);
      chk("t6_pre_vld", mv, 3'b100);
      #2 ARESETn = 1'b0;
      #1;
      chk("t6_vld_async", mv, 3'b000);
      chk("t6_RDY", RDY, 1);
      chk("t6_drop", drop_cnt, 0);
      chk("t6_sel_rdy", s_axis_tready_sel, 1);
      @(negedge ACLK); ARESETn = 1'b1; m_axis_tready_2 = 1'b1;
      @(posedge ACLK); #1;
      send_pkt(32'h6200_0001, 2);
      idle(3);
      expect_port("t6_out0", 0, 32'h6200_0001, 2);
      expect_empty("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
